// File: rtl/sipo_deser_if.sv
// Serial-in / parallel-out bus bundle for sipo_deser.
// Latency: none, this is wiring only.
// Backpressure: out_ready from the consumer, with no backpressure toward the serial side.
// Ports: s_in, s_valid and clr are the serial side; out, out_valid and out_ready are the
//        word handshake; bit_cnt and overrun are status.
interface sipo_deser_if #(
  parameter int WIDTH = 8
);
  logic                       s_in;
  logic                       s_valid;
  logic                       clr;
  logic                       out_ready;
  logic [WIDTH-1:0]           out;
  logic                       out_valid;
  logic [$clog2(WIDTH)-1:0]   bit_cnt;
  logic                       overrun;

  // The deserializer owns the parallel side and the status signals.
  modport slave (
    input  s_in, s_valid, clr, out_ready,
    output out, out_valid, bit_cnt, overrun
  );

  // The environment drives the serial bits and consumes the words.
  modport master (
    output s_in, s_valid, clr, out_ready,
    input  out, out_valid, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_deser.sv
// Deserializer: collects WIDTH qualified serial bits into a word, with the bit order set by MSB_FIRST.
// Latency: a word is visible on out/out_valid in the cycle after its last bit is sampled.
// Backpressure: a single holding register; a completed word that finds it full is dropped and sets sticky overrun.
// Ports: clk, rst (synchronous, active-low), bus (sipo_deser_if.slave).
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  sipo_deser_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] out_q;
  logic             vld_q;
  logic             ovr_q;
  logic             last;
  logic             free;

  // The shifted value includes the current bit, so it is also the completed word.
  always_comb begin
    sr_next = sr;
    if (MSB_FIRST) sr_next = {sr[WIDTH-2:0], bus.s_in};
    else           sr_next = {bus.s_in, sr[WIDTH-1:1]};
  end

  // clr discards a simultaneous bit, so that bit can never complete a frame.
  assign last = bus.s_valid && !bus.clr && (cnt == LAST);
  // The holding register can take a word if it is empty or is being drained on this edge.
  assign free = !vld_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr    <= '0;
      cnt   <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (bus.clr) begin
        sr    <= '0;
        cnt   <= '0;
        ovr_q <= 1'b0;
      end else if (bus.s_valid) begin
        if (cnt == LAST) begin
          sr  <= '0;
          cnt <= '0;
          if (!free) ovr_q <= 1'b1;
        end else begin
          sr  <= sr_next;
          cnt <= cnt + CW'(1);
        end
      end

      // A load on a draining edge keeps out_valid high with the new word.
      if (last && free) begin
        out_q <= sr_next;
        vld_q <= 1'b1;
      end else if (vld_q && bus.out_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;
  assign bus.bit_cnt   = cnt;
  assign bus.overrun   = ovr_q;
endmodule

// File: doc/sipo_deser.md
# sipo_deser

Parametrised serial-in/parallel-out deserializer with framing and an output handshake. It collects `WIDTH` qualified serial bits into a word, with the bit order selectable by parameter. Each completed word is presented on a held parallel register with a valid/ready handshake. The block sits behind a serial receive front end and feeds word-oriented logic. It supersedes the fixed 8-bit free-running SIPO.

## Interface
- `WIDTH`, 8: bits per word; legal range is 2 or more.
- `MSB_FIRST`, 1: bit order.
  - 1: the first received bit lands in `out[WIDTH-1]`.
  - 0: the first received bit lands in `out[0]`.
- `clk` input 1: single clock; all logic updates on the rising edge.
- `rst` input 1: reset, synchronous and active-low; sampled on the `clk` rising edge.
- `s_in` input 1: serial data bit.
- `s_valid` input 1: when 1, `s_in` is sampled this cycle.
- `clr` input 1: synchronous frame restart.
- `out_ready` input 1: the consumer accepts `out` when `out_valid` is 1.
- `out` output `WIDTH`: last completed word, held.
- `out_valid` output 1: `out` holds an unconsumed word.
- `bit_cnt` output `$clog2(WIDTH)`: number of bits collected in the current frame.
- `overrun` output 1: sticky flag; a completed word was dropped.

## Operation
- **Internal state:**
  - shift register `sr[WIDTH-1:0]`
  - counter `bit_cnt`, range 0..WIDTH-1
  - holding register `out`
  - `out_valid` and `overrun` flags
- **Reset (`rst`=0 at an edge):** sr, `bit_cnt`, `out`, `out_valid` and `overrun` all become 0. Reset has priority over every other input, including mid-frame; a partial frame is discarded.
- **Sampling (`s_valid`=1 and `clr`=0):**
  - `MSB_FIRST`=1: `sr <= {sr[WIDTH-2:0], s_in}`.
  - `MSB_FIRST`=0: `sr <= {s_in, sr[WIDTH-1:1]}`.
  - If `bit_cnt` < WIDTH-1, then `bit_cnt` increments.
- **Frame completion:** `s_valid`=1 and `bit_cnt`=WIDTH-1.
  - The completed word is the shifted value, including the current `s_in`.
  - `bit_cnt` wraps to 0 and sr clears to 0.
  - If the holding register is free, the word is loaded into `out` and `out_valid` is set.
  - The holding register is free when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 on the same edge.
  - Otherwise the word is dropped, `out` is unchanged and `overrun` is set.
- **`s_valid`=0:** sr and `bit_cnt` hold; gaps between qualified bits are allowed at any point.
- **Handshake:**
  - A transfer occurs on an edge where `out_valid`=1 and `out_ready`=1.
  - After a transfer, `out_valid` clears unless a new word loads on the same edge, in which case it stays 1 with the new `out`.
  - `out` holds its value while `out_valid`=1 and `out_ready`=0.
- **`clr`=1:**
  - sr, `bit_cnt` and `overrun` clear to 0.
  - A simultaneous `s_valid` bit is discarded; `clr` wins.
  - `out` and `out_valid` are unaffected, and a handshake transfer on the same edge still completes.
- `out_ready` while `out_valid`=0 has no effect.

## Timing
- Reset values: `out`=0, `out_valid`=0, `bit_cnt`=0, `overrun`=0, from the edge at which `rst`=0 is sampled.
- **Latency:** `out` and `out_valid` update at the same edge that samples the last bit of a frame, and are visible in the following cycle. There is no further pipeline stage.
- **Throughput:** one bit per cycle. Back-to-back frames need no idle cycle.
- `bit_cnt` is registered; it reads k after k qualified bits of the current frame.
- `overrun` asserts in the cycle after the dropping edge. It is cleared only by `rst` or `clr`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
1. **MSB-first word:** `WIDTH`=8, `MSB_FIRST`=1. After reset, send bits 1,0,1,1,0,0,1,1 with `s_valid`=1 on consecutive cycles and `out_ready`=0.
   - Required: `out`=8'hB3 and `out_valid`=1 in the cycle after the 8th bit.
   - Required: `bit_cnt` steps 1..7, then 0.
2. **LSB-first word:** same stimulus with `MSB_FIRST`=0.
   - Required: `out`=8'hCD.
   - Required: `s_valid` gaps of 3 idle cycles inserted between bits do not change the result.
3. **Back-to-back with drain:** send 0xB3 then 0x5A MSB-first, with `out_ready`=1 on the edge the second word completes.
   - Required: `out`=8'h5A and `out_valid` stays 1 continuously.
   - Required: `overrun`=0.
4. **Overrun:** hold `out_ready`=0 and send two full words, 0xB3 then 0xFF.
   - Required: `out` stays 8'hB3 and `overrun`=1.
   - Then apply `clr`: `overrun`=0, while `out` and `out_valid` remain unchanged.
5. **Mid-frame `clr`:** send 4 bits, pulse `clr` together with `s_valid`=1, then send 0x3C.
   - Required: `bit_cnt`=0 after `clr`, and the next word is exactly 8'h3C.
6. **Mid-frame reset:** send 5 bits of a word while `out_valid`=1 holds 0xB3, then drive `rst`=0 for one cycle.
   - Required: all outputs are 0.
   - Required: a following 8-bit frame 0xA5 yields `out`=8'hA5.
